// File: rtl/wedge_accept_ctrl.sv
// Wedge-test sequencer for the GRNG core.
// Takes one candidate at a time, presents it to the wedge comparator,
// waits out the comparator latency, then either emits the sample
// downstream or drops it and counts the rejection.
module wedge_accept_ctrl #(
  parameter int unsigned CMP_LATENCY = 1,   // 1..7
  parameter int unsigned MAX_REJECT  = 64   // 1..65535
) (
  input  logic        clk_i,
  input  logic        rst_i,

  // Candidate stream
  input  logic        cand_valid_i,
  output logic        cand_ready_o,
  input  logic [31:0] cand_abs_i,
  input  logic        cand_sign_i,
  input  logic [31:0] cand_ratio_i,

  // Comparator interface
  output logic [31:0] abs_value_o,
  output logic [31:0] wedge_bound_ratio_o,
  input  logic        cmp_value_i,

  // Accepted sample stream
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_sample_o,
  output logic        out_sign_o,

  // Statistics
  output logic        reject_pulse_o,
  output logic [15:0] reject_cnt_o,
  output logic        err_runaway_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDecide, StOut} state_e;

  localparam logic [2:0]  WaitLast = 3'(CMP_LATENCY - 1);
  localparam logic [15:0] MaxRej   = 16'(MAX_REJECT);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        cand_ready_q, cand_ready_d;
  logic [31:0] abs_q, abs_d;
  logic [31:0] ratio_q, ratio_d;
  logic        sign_q, sign_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_sample_q, out_sample_d;
  logic        out_sign_q, out_sign_d;
  logic        reject_pulse_q, reject_pulse_d;
  logic [15:0] reject_cnt_q, reject_cnt_d;
  logic [15:0] consec_q, consec_d;
  logic        err_q, err_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    cand_ready_d   = cand_ready_q;
    abs_d          = abs_q;
    ratio_d        = ratio_q;
    sign_d         = sign_q;
    out_valid_d    = out_valid_q;
    out_sample_d   = out_sample_q;
    out_sign_d     = out_sign_q;
    reject_pulse_d = 1'b0;
    reject_cnt_d   = reject_cnt_q;
    consec_d       = consec_q;
    err_d          = err_q;

    unique case (state_q)
      StIdle: begin
        // cand_ready is registered, so it only rises one cycle after reset release.
        cand_ready_d = 1'b1;
        if (cand_valid_i && cand_ready_q) begin
          abs_d        = cand_abs_i;
          ratio_d      = cand_ratio_i;
          sign_d       = cand_sign_i;
          wait_d       = 3'd0;
          cand_ready_d = 1'b0;
          state_d      = StWait;
        end
      end

      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StDecide;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      StDecide: begin
        if (cmp_value_i) begin
          out_valid_d  = 1'b1;
          out_sample_d = abs_q;
          out_sign_d   = sign_q;
          consec_d     = 16'd0;
          state_d      = StOut;
        end else begin
          reject_pulse_d = 1'b1;
          cand_ready_d   = 1'b1;
          state_d        = StIdle;
          if (reject_cnt_q != 16'hFFFF) begin
            reject_cnt_d = reject_cnt_q + 16'd1;
          end
          if (consec_q != MaxRej) begin
            consec_d = consec_q + 16'd1;
          end
          // Sticky: only reset clears the runaway flag.
          if (consec_d == MaxRej) begin
            err_d = 1'b1;
          end
        end
      end

      StOut: begin
        if (out_ready_i) begin
          out_valid_d  = 1'b0;
          cand_ready_d = 1'b1;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      wait_q         <= 3'd0;
      cand_ready_q   <= 1'b0;
      abs_q          <= 32'd0;
      ratio_q        <= 32'd0;
      sign_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sample_q   <= 32'd0;
      out_sign_q     <= 1'b0;
      reject_pulse_q <= 1'b0;
      reject_cnt_q   <= 16'd0;
      consec_q       <= 16'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      cand_ready_q   <= cand_ready_d;
      abs_q          <= abs_d;
      ratio_q        <= ratio_d;
      sign_q         <= sign_d;
      out_valid_q    <= out_valid_d;
      out_sample_q   <= out_sample_d;
      out_sign_q     <= out_sign_d;
      reject_pulse_q <= reject_pulse_d;
      reject_cnt_q   <= reject_cnt_d;
      consec_q       <= consec_d;
      err_q          <= err_d;
    end
  end

  assign cand_ready_o        = cand_ready_q;
  assign abs_value_o         = abs_q;
  assign wedge_bound_ratio_o = ratio_q;
  assign out_valid_o         = out_valid_q;
  assign out_sample_o        = out_sample_q;
  assign out_sign_o          = out_sign_q;
  assign reject_pulse_o      = reject_pulse_q;
  assign reject_cnt_o        = reject_cnt_q;
  assign err_runaway_o       = err_q;

endmodule

// File: tb/tb_wedge_accept_ctrl.sv
// Bench for wedge_accept_ctrl: two instances (latency 1 / max 4, latency 3 / max 64)
// share stimulus; the idle one is held in reset and 'sel' picks which is observed.
module tb_wedge_accept_ctrl;

  logic        clk = 1'b0;
  logic        rst, sel;
  logic        cand_valid, cand_sign, cmp_value, out_ready;
  logic [31:0] cand_abs, cand_ratio;

  logic        o1_cand_ready, o1_out_valid, o1_out_sign, o1_rej_pulse, o1_err;
  logic [31:0] o1_abs, o1_ratio, o1_out_sample;
  logic [15:0] o1_rej_cnt;
  logic        o3_cand_ready, o3_out_valid, o3_out_sign, o3_rej_pulse, o3_err;
  logic [31:0] o3_abs, o3_ratio, o3_out_sample;
  logic [15:0] o3_rej_cnt;

  logic        cand_ready, out_valid, out_sign, rej_pulse, err;
  logic [31:0] abs_v, ratio_v, out_sample;
  logic [15:0] rej_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int lat;
  int maxrej;
  int m_rej;
  int m_consec;
  bit m_err;

  always #5 clk = ~clk;

  wedge_accept_ctrl #(.CMP_LATENCY(1), .MAX_REJECT(4)) dut1 (
    .clk_i(clk), .rst_i(rst | sel),
    .cand_valid_i(cand_valid), .cand_ready_o(o1_cand_ready),
    .cand_abs_i(cand_abs), .cand_sign_i(cand_sign), .cand_ratio_i(cand_ratio),
    .abs_value_o(o1_abs), .wedge_bound_ratio_o(o1_ratio), .cmp_value_i(cmp_value),
    .out_valid_o(o1_out_valid), .out_ready_i(out_ready),
    .out_sample_o(o1_out_sample), .out_sign_o(o1_out_sign),
    .reject_pulse_o(o1_rej_pulse), .reject_cnt_o(o1_rej_cnt), .err_runaway_o(o1_err)
  );

  wedge_accept_ctrl #(.CMP_LATENCY(3), .MAX_REJECT(64)) dut3 (
    .clk_i(clk), .rst_i(rst | ~sel),
    .cand_valid_i(cand_valid), .cand_ready_o(o3_cand_ready),
    .cand_abs_i(cand_abs), .cand_sign_i(cand_sign), .cand_ratio_i(cand_ratio),
    .abs_value_o(o3_abs), .wedge_bound_ratio_o(o3_ratio), .cmp_value_i(cmp_value),
    .out_valid_o(o3_out_valid), .out_ready_i(out_ready),
    .out_sample_o(o3_out_sample), .out_sign_o(o3_out_sign),
    .reject_pulse_o(o3_rej_pulse), .reject_cnt_o(o3_rej_cnt), .err_runaway_o(o3_err)
  );

  assign cand_ready = sel ? o3_cand_ready : o1_cand_ready;
  assign abs_v      = sel ? o3_abs        : o1_abs;
  assign ratio_v    = sel ? o3_ratio      : o1_ratio;
  assign out_valid  = sel ? o3_out_valid  : o1_out_valid;
  assign out_sample = sel ? o3_out_sample : o1_out_sample;
  assign out_sign   = sel ? o3_out_sign   : o1_out_sign;
  assign rej_pulse  = sel ? o3_rej_pulse  : o1_rej_pulse;
  assign rej_cnt    = sel ? o3_rej_cnt    : o1_rej_cnt;
  assign err        = sel ? o3_err        : o1_err;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic which);
    rst = 1'b1;
    sel = which;
    cand_valid = 1'b0;
    out_ready = 1'b0;
    cmp_value = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    m_rej = 0;
    m_consec = 0;
    m_err = 1'b0;
    lat = which ? 3 : 1;
    maxrej = which ? 64 : 4;
  endtask

  // One full candidate transaction. 'acc' is the comparator verdict presented
  // during the decide cycle; 'hold' is how many OUT cycles out_ready stays low.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] r, input logic s,
                        input bit acc, input int hold);
    int n = 0;
    while (cand_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (cand_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: cand_ready=%b required 1", cand_ready);
    end
    cand_valid = 1'b1;
    cand_abs   = a;
    cand_ratio = r;
    cand_sign  = s;
    tick();  // edge E
    // Now observing E+1; the decide cycle is observed at E+lat+1.
    for (int k = 1; k <= lat + 1; k++) begin
      cand_valid = 1'($urandom);
      cand_abs   = $urandom;
      cand_ratio = $urandom;
      cand_sign  = 1'($urandom);
      out_ready  = 1'($urandom);
      cmp_value  = (k == lat + 1) ? acc : ~acc;
      total++;
      if (abs_v !== a || ratio_v !== r) begin
        bad++;
        $display("FAIL operands_wait k=%0d: abs=%h ratio=%h required %h %h", k, abs_v, ratio_v, a, r);
      end
      total++;
      if ({out_valid, cand_ready, rej_pulse} !== 3'b000) begin
        bad++;
        $display("FAIL busy_flags k=%0d: valid/ready/pulse=%b required 000", k,
                 {out_valid, cand_ready, rej_pulse});
      end
      tick();
    end
    cand_valid = 1'b0;
    cmp_value  = 1'($urandom);
    out_ready  = 1'b0;
    // Observing E+lat+2.
    if (acc) begin
      m_consec = 0;
      total++;
      if (out_valid !== 1'b1 || out_sample !== a || out_sign !== s || rej_pulse !== 1'b0) begin
        bad++;
        $display("FAIL accept_out: valid=%b sample=%h sign=%b pulse=%b required 1 %h %b 0",
                 out_valid, out_sample, out_sign, rej_pulse, a, s);
      end
      total++;
      if (rej_cnt !== 16'(m_rej) || err !== m_err) begin
        bad++;
        $display("FAIL accept_stats: cnt=%0d err=%b required %0d %b", rej_cnt, err, m_rej, m_err);
      end
      for (int h = 0; h <= hold; h++) begin
        out_ready  = (h == hold);
        cand_valid = 1'($urandom);
        total++;
        if (out_valid !== 1'b1 || out_sample !== a || out_sign !== s || cand_ready !== 1'b0 ||
            abs_v !== a || ratio_v !== r) begin
          bad++;
          $display("FAIL out_hold h=%0d: valid=%b sample=%h sign=%b ready=%b abs=%h required 1 %h %b 0 %h",
                   h, out_valid, out_sample, out_sign, cand_ready, abs_v, a, s, a);
        end
        tick();
      end
      out_ready  = 1'b0;
      cand_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || cand_ready !== 1'b1 || abs_v !== a || ratio_v !== r) begin
        bad++;
        $display("FAIL out_release: valid=%b ready=%b abs=%h required 0 1 %h",
                 out_valid, cand_ready, abs_v, a);
      end
    end else begin
      if (m_rej < 65535) m_rej++;
      if (m_consec < maxrej) m_consec++;
      if (m_consec >= maxrej) m_err = 1'b1;
      total++;
      if (rej_pulse !== 1'b1 || cand_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reject_flags: pulse=%b ready=%b valid=%b required 1 1 0",
                 rej_pulse, cand_ready, out_valid);
      end
      total++;
      if (rej_cnt !== 16'(m_rej) || err !== m_err) begin
        bad++;
        $display("FAIL reject_stats: cnt=%0d err=%b required %0d %b", rej_cnt, err, m_rej, m_err);
      end
      tick();
      total++;
      if (rej_pulse !== 1'b0 || cand_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reject_pulse_end: pulse=%b ready=%b valid=%b required 0 1 0",
                 rej_pulse, cand_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    cand_valid = 1'b1;
    out_ready = 1'b1;
    cmp_value = 1'b1;
    cand_abs = 32'hFFFF_FFFF;
    cand_ratio = 32'hFFFF_FFFF;
    cand_sign = 1'b1;
    tick();
    tick();
    total++;
    if ({cand_ready, abs_v, ratio_v, out_valid, out_sample, out_sign, rej_pulse, rej_cnt, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b abs=%h valid=%b cnt=%0d err=%b required all 0",
               cand_ready, abs_v, out_valid, rej_cnt, err);
    end
    cand_valid = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (cand_ready !== 1'b1 || out_valid !== 1'b0 || rej_cnt !== 16'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b valid=%b cnt=%0d err=%b required 1 0 0 0",
               cand_ready, out_valid, rej_cnt, err);
    end
    m_rej = 0;
    m_consec = 0;
    m_err = 1'b0;
    lat = 1;
    maxrej = 4;
  endtask

  task automatic test_accept();
    do_txn(32'h1F93_AABC, 32'h1F93_AABB, 1'b1, 1'b1, 0);
  endtask

  task automatic test_reject();
    do_txn(32'hFEDC_BA98, 32'h789A_BCDE, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_txn(32'h0123_4567, 32'h0765_4321, 1'b0, 1'b1, 5);
  endtask

  task automatic test_runaway();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) do_txn($urandom, $urandom, 1'($urandom), 1'b0, 0);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL runaway_set: err=%b required 1", err);
    end
    do_txn($urandom, $urandom, 1'($urandom), 1'b1, 1);
    for (int i = 0; i < 3; i++) do_txn($urandom, $urandom, 1'($urandom), 1'b0, 0);
  endtask

  task automatic test_reset_in_wait();
    while (cand_ready !== 1'b1) tick();
    cand_valid = 1'b1;
    cand_abs = 32'hA5A5_5A5A;
    cand_ratio = 32'h5A5A_A5A5;
    cand_sign = 1'b1;
    tick();  // capture edge; now in WAIT
    cand_valid = 1'b0;
    rst = 1'b1;
    cmp_value = 1'b0;
    tick();
    total++;
    if ({cand_ready, abs_v, ratio_v, out_valid, out_sample, out_sign, rej_pulse, rej_cnt, err} !== '0) begin
      bad++;
      $display("FAIL wait_reset: ready=%b abs=%h valid=%b pulse=%b cnt=%0d required all 0",
               cand_ready, abs_v, out_valid, rej_pulse, rej_cnt);
    end
    rst = 1'b0;
    tick();
    m_rej = 0;
    m_consec = 0;
    m_err = 1'b0;
    total++;
    if (cand_ready !== 1'b1 || rej_pulse !== 1'b0 || rej_cnt !== 16'd0) begin
      bad++;
      $display("FAIL wait_reset_release: ready=%b pulse=%b cnt=%0d required 1 0 0",
               cand_ready, rej_pulse, rej_cnt);
    end
    do_txn(32'h3333_4444, 32'h1111_2222, 1'b0, 1'b1, 0);
  endtask

  task automatic test_latency3();
    do_reset(1'b1);
    do_txn(32'h1F93_AABC, 32'h1F93_AABB, 1'b1, 1'b1, 2);
    do_txn(32'hFEDC_BA98, 32'h789A_BCDE, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) do_txn($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) do_txn($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_backpressure();
    test_runaway();
    test_reset_in_wait();
    test_random();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wedge_accept_ctrl.md
Name: wedge_accept_ctrl

Overview:
- Initiator/sequencer for the wedge comparator in the GRNG core.
- Accepts candidate samples (magnitude, sign, wedge bound ratio) over a valid/ready stream and presents operands to the comparator's abs_value/wedge_bound_ratio inputs.
- Waits out the comparator's registered latency, samples cmp_value, then emits the accepted sample downstream or drops it and requests a new candidate.
- Keeps reject statistics and flags a runaway-rejection condition.

Parameters:
- CMP_LATENCY, 1: cycles from operands stable at comparator inputs to cmp_value valid (1..7).
- MAX_REJECT, 64: consecutive rejects that set err_runaway (1..65535).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cand_valid  in  1  candidate present.
- cand_ready  out  1  controller can take a candidate.
- cand_abs  in  32  candidate magnitude, UQ4.28.
- cand_sign  in  1  candidate sign.
- cand_ratio  in  32  wedge bound ratio for the candidate's layer, UQ4.28.
- abs_value  out  32  to comparator, UQ4.28, registered.
- wedge_bound_ratio  out  32  to comparator, UQ4.28, registered.
- cmp_value  in  1  comparator result; 1 = accept.
- out_valid  out  1  accepted sample available.
- out_ready  in  1  downstream accepts.
- out_sample  out  32  accepted magnitude, UQ4.28.
- out_sign  out  1  accepted sign.
- reject_pulse  out  1  one-cycle pulse per rejected candidate.
- reject_cnt  out  16  total rejects, saturating at 16'hFFFF.
- err_runaway  out  1  sticky; set when consecutive rejects reach MAX_REJECT.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - All outputs are 0, except cand_ready=1 in the first cycle after reset is released.
  - Counters and err_runaway are cleared.
- States: IDLE, WAIT, DECIDE, OUT. cand_ready=1 only in IDLE.
- IDLE:
  - On cand_valid & cand_ready at edge E, register cand_abs→abs_value, cand_ratio→wedge_bound_ratio, and latch the sign.
  - Go to WAIT with the wait counter at 0.
- WAIT:
  - Stay exactly CMP_LATENCY cycles, then go to DECIDE.
  - abs_value and wedge_bound_ratio are held stable from E until the next candidate is captured; they never change outside IDLE.
- DECIDE: one cycle; cmp_value is sampled at the end of this cycle.
  - cmp_value=1 → OUT. out_sample=abs_value and out_sign=latched sign, both registered. The consecutive-reject counter is cleared.
  - cmp_value=0 → IDLE. reject_pulse=1 for the next cycle. reject_cnt increments, saturating. The consecutive counter increments, saturating at MAX_REJECT; reaching MAX_REJECT sets err_runaway.
- OUT:
  - out_valid=1 and out_sample/out_sign are held stable until out_ready is high at an edge; then go to IDLE.
  - out_ready is ignored in all other states.
- Timing:
  - Latency: out_valid first high CMP_LATENCY+2 cycles after edge E (3 for the default).
  - Reject turnaround: cand_ready high again CMP_LATENCY+2 cycles after E.
  - Throughput: one candidate per CMP_LATENCY+3 cycles at best; no overlap or bypass.
- cand_valid is don't-care outside IDLE; a pending candidate is not consumed.
- err_runaway stays set until rst; it does not block operation.
- Reset asserted in any state aborts the transaction in the next cycle. The in-flight candidate is lost, with no reject_pulse or count.

Test Plan:
- Reset, then cand_abs=32'h1F93_AABC, cand_ratio=32'h1F93_AABB, sign=1; bench drives cmp_value=1 in DECIDE.
  → abs_value/wedge_bound_ratio equal those values from E+1; out_valid at E+3; out_sample=32'h1F93_AABC, out_sign=1; reject_cnt=0.
- cand_abs=32'hFEDC_BA98, ratio=32'h789A_BCDE, cmp_value=0.
  → no out_valid; reject_pulse exactly one cycle; reject_cnt=1; cand_ready high at E+3.
- Accept with out_ready held low 5 cycles.
  → out_valid and out_sample stable for all 5; return to IDLE one cycle after out_ready rises; cand_ready=0 throughout.
- MAX_REJECT=4, four rejects in a row.
  → err_runaway set after the 4th DECIDE.
  - Then an accept: err_runaway stays 1 and the consecutive count clears.
  - Then three more rejects: no new error event.
- rst asserted during WAIT.
  → next cycle: all outputs 0, reject_cnt unchanged at 0, cand_ready=1 after release.
  - The next candidate completes normally.
- CMP_LATENCY=3, accept case.
  → out_valid at E+5; operands stable from E+1 through the OUT handshake.
